// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the arbiter and the register file.
// The arbiter takes the slave view; requesters and the regfile side take the master view.
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  A_Valid;
  logic                  A_Ready;
  logic [ADDR_WIDTH-1:0] A_Addr;
  logic [DATA_WIDTH-1:0] A_Data;
  logic                  B_Valid;
  logic                  B_Ready;
  logic [ADDR_WIDTH-1:0] B_Addr;
  logic [DATA_WIDTH-1:0] B_Data;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  InitDone;

  modport slave (
    input  A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
    output A_Ready, B_Ready, RegWrite, WriteRegister, WriteData, InitDone
  );

  modport master (
    output A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
    input  A_Ready, B_Ready, RegWrite, WriteRegister, WriteData, InitDone
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: init sweep after reset, then round-robin
// arbitration between requesters A and B with one registered write per cycle.
module regfile_write_arbiter #(
  parameter int                    NUM_REGS   = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input logic                   Clk,
  input logic                   Reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG  = {ADDR_WIDTH{1'b0}};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ptr_b;
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_wreg;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_initdone;

  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // Grant decision; r_ptr_b names the requester that wins a contested cycle.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!Reset && (r_state == ST_ARB)) begin
      if (bus.A_Valid && (!bus.B_Valid || !r_ptr_b)) begin
        w_grant_a = 1'b1;
      end else if (bus.B_Valid) begin
        w_grant_b = 1'b1;
      end else begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
      end
    end else begin
      w_grant_a = 1'b0;
      w_grant_b = 1'b0;
    end
  end

  // Select the granted requester's address and data.
  always_comb begin
    w_xfer = w_grant_a | w_grant_b;
    if (w_grant_a) begin
      w_addr = bus.A_Addr;
      w_data = bus.A_Data;
    end else begin
      w_addr = bus.B_Addr;
      w_data = bus.B_Data;
    end
  end

  assign bus.A_Ready       = w_grant_a;
  assign bus.B_Ready       = w_grant_b;
  assign bus.RegWrite      = r_regwrite;
  assign bus.WriteRegister = r_wreg;
  assign bus.WriteData     = r_wdata;
  assign bus.InitDone      = r_initdone;

  // Sweep/arbitration state machine with registered write-port outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_INIT;
      r_cnt      <= FIRST_REG;
      r_ptr_b    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wreg     <= ZERO_REG;
      r_wdata    <= {DATA_WIDTH{1'b0}};
      r_initdone <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_regwrite <= 1'b1;
          r_wreg     <= r_cnt;
          r_wdata    <= INIT_VALUE;
          if (r_cnt == LAST_REG) begin
            r_state    <= ST_ARB;
            r_initdone <= 1'b1;
          end else begin
            r_cnt <= r_cnt + FIRST_REG;
          end
        end
        ST_ARB: begin
          // Register 0 writes are accepted but never enabled toward the file.
          if (w_xfer) begin
            r_regwrite <= (w_addr != ZERO_REG);
            r_wreg     <= w_addr;
            r_wdata    <= w_data;
            r_ptr_b    <= w_grant_a;
          end else begin
            r_regwrite <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_INIT;
          r_cnt      <= FIRST_REG;
          r_regwrite <= 1'b0;
          r_initdone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of grants, the write port and register-file contents.
module tb_regfile_write_arbiter;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic Clk;
  logic Reset;
  logic fill;

  regfile_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  regfile_write_arbiter #(
    .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(32'h0000_0000)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Stand-in for the downstream register file, preloaded with garbage.
  logic [DW-1:0] tb_rf [NR];
  always @(posedge Clk) begin
    if (fill) begin
      for (int r = 0; r < NR; r++) tb_rf[r] <= 32'hA5A5_A5A5;
    end else if (bus.RegWrite && (bus.WriteRegister != 5'd0)) begin
      tb_rf[bus.WriteRegister] <= bus.WriteData;
    end
  end

  function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] a);
    return (a == 5'd0) ? 32'h0 : tb_rf[a];
  endfunction

  // Reference model state
  bit            m_arb;
  bit            m_ptr_b;
  logic          m_rw;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rf [NR];
  bit            e_ga, e_gb;

  // Observed DUT values
  logic          o_ar, o_br, o_rw, o_done;
  logic [AW-1:0] o_wreg;
  logic [DW-1:0] o_wdata;

  task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus.A_Valid = av; bus.A_Addr = aa; bus.A_Data = ad;
    bus.B_Valid = bv; bus.B_Addr = ba; bus.B_Data = bd;
    e_ga = 1'b0; e_gb = 1'b0;
    if (m_arb) begin
      if (av && bv) begin
        if (m_ptr_b) e_gb = 1'b1; else e_ga = 1'b1;
      end else if (av) e_ga = 1'b1;
      else if (bv) e_gb = 1'b1;
    end
    @(negedge Clk);
    o_ar = bus.A_Ready; o_br = bus.B_Ready;
    @(posedge Clk); #1;
    o_rw = bus.RegWrite; o_wreg = bus.WriteRegister; o_wdata = bus.WriteData; o_done = bus.InitDone;
    if (m_arb) begin
      if (e_ga) begin
        m_rw = (aa != 5'd0); m_wreg = aa; m_wdata = ad; m_ptr_b = 1'b1;
        if (aa != 5'd0) m_rf[aa] = ad;
      end else if (e_gb) begin
        m_rw = (ba != 5'd0); m_wreg = ba; m_wdata = bd; m_ptr_b = 1'b0;
        if (ba != 5'd0) m_rf[ba] = bd;
      end else begin
        m_rw = 1'b0;
      end
    end
  endtask

  task automatic test_reset(input int n);
    Reset = 1'b1;
    bus.A_Valid = 1'b1; bus.A_Addr = 5'd3; bus.A_Data = 32'h1;
    bus.B_Valid = 1'b1; bus.B_Addr = 5'd4; bus.B_Data = 32'h2;
    @(negedge Clk);
    checks++;
    if ({bus.A_Ready, bus.B_Ready} !== 2'b00)
      $display("FAIL reset_ready: got %b required 00", {bus.A_Ready, bus.B_Ready});
    if ({bus.A_Ready, bus.B_Ready} !== 2'b00) errors++;
    repeat (n) @(posedge Clk);
    #1;
    checks++;
    if ({bus.RegWrite, bus.InitDone} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: RegWrite/InitDone got %b required 00", {bus.RegWrite, bus.InitDone});
    end
    checks++;
    if (bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'h0) begin
      errors++; $display("FAIL reset_bus: got reg %0d data %h required 0/0", bus.WriteRegister, bus.WriteData);
    end
    m_arb = 1'b0; m_ptr_b = 1'b0; m_rw = 1'b0; m_wreg = 5'd0; m_wdata = 32'h0;
    Reset = 1'b0; fill = 1'b0;
    bus.A_Valid = 1'b0; bus.B_Valid = 1'b0;
  endtask

  task automatic test_init_sweep(input int last_k, input bit noisy);
    logic exp_done;
    for (int k = 1; k <= last_k; k++) begin
      bus.A_Valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.B_Valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.A_Addr = 5'($urandom_range(0, 31)); bus.A_Data = $urandom;
      bus.B_Addr = 5'($urandom_range(0, 31)); bus.B_Data = $urandom;
      @(negedge Clk);
      checks++;
      if ((bus.A_Ready | bus.B_Ready) !== 1'b0) begin
        errors++; $display("FAIL sweep_ready k=%0d: got %b%b required 00", k, bus.A_Ready, bus.B_Ready);
      end
      @(posedge Clk); #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== AW'(k) || bus.WriteData !== 32'h0) begin
        errors++;
        $display("FAIL sweep_write k=%0d: got rw=%b reg=%0d data=%h required 1/%0d/0",
                 k, bus.RegWrite, bus.WriteRegister, bus.WriteData, k);
      end
      exp_done = (k == NR - 1) ? 1'b1 : 1'b0;
      checks++;
      if (bus.InitDone !== exp_done) begin
        errors++; $display("FAIL sweep_done k=%0d: got %b required %b", k, bus.InitDone, exp_done);
      end
    end
    bus.A_Valid = 1'b0; bus.B_Valid = 1'b0;
    if (last_k == NR - 1) begin
      m_arb = 1'b1; m_rw = 1'b1; m_wreg = AW'(NR - 1); m_wdata = 32'h0;
      for (int r = 0; r < NR; r++) m_rf[r] = 32'h0;
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checks++;
      if (o_rw !== 1'b0 || o_done !== 1'b1) begin
        errors++; $display("FAIL post_sweep_idle: got rw=%b done=%b required 0/1", o_rw, o_done);
      end
      for (int r = 1; r < NR; r++) begin
        checks++;
        if (rf_read(AW'(r)) !== 32'h0) begin
          errors++; $display("FAIL sweep_contents r%0d: got %h required 0", r, rf_read(AW'(r)));
        end
      end
    end
  endtask

  task automatic test_single_write();
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({o_ar, o_br} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b%b required 10", o_ar, o_br);
    end
    checks++;
    if (o_rw !== 1'b1 || o_wreg !== 5'd5 || o_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write: got %b/%0d/%h required 1/5/deadbeef", o_rw, o_wreg, o_wdata);
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (o_rw !== 1'b0 || o_wreg !== 5'd5 || o_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL idle_hold: got %b/%0d/%h required 0/5/deadbeef", o_rw, o_wreg, o_wdata);
    end
    checks++;
    if (rf_read(5'd5) !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_rf: got %h required deadbeef", rf_read(5'd5));
    end
  endtask

  task automatic test_contested();
    logic [AW-1:0] aq[$];
    logic [AW-1:0] bq[$];
    bit            exp_b [4];
    logic [AW-1:0] exp_a;
    logic          av, bv;
    aq = '{5'd1, 5'd2};
    bq = '{5'd3, 5'd4};
    exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
    // Uncontested B write first so the pointer names A
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h8);
    checks++;
    if ({o_ar, o_br} !== 2'b01) begin
      errors++; $display("FAIL filler_b_ready: got %b%b required 01", o_ar, o_br);
    end
    for (int i = 0; i < 4; i++) begin
      av = (aq.size() > 0);
      bv = (bq.size() > 0);
      exp_a = exp_b[i] ? (bv ? bq[0] : 5'd0) : (av ? aq[0] : 5'd0);
      step(av, av ? aq[0] : 5'd0, av ? DW'(aq[0]) : 32'h0,
           bv, bv ? bq[0] : 5'd0, bv ? DW'(bq[0]) : 32'h0);
      checks++;
      if ((o_ar ^ o_br) !== 1'b1) begin
        errors++; $display("FAIL one_ready i=%0d: got %b%b required exactly one", i, o_ar, o_br);
      end
      checks++;
      if (o_br !== exp_b[i]) begin
        errors++; $display("FAIL grant_order i=%0d: got B_Ready=%b required %b", i, o_br, exp_b[i]);
      end
      checks++;
      if (o_rw !== 1'b1 || o_wreg !== exp_a || o_wdata !== DW'(exp_a)) begin
        errors++; $display("FAIL contested_write i=%0d: got %b/%0d/%h required 1/%0d/%0h", i, o_rw, o_wreg, o_wdata, exp_a, exp_a);
      end
      if (o_ar && aq.size() > 0) void'(aq.pop_front());
      if (o_br && bq.size() > 0) void'(bq.pop_front());
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int n = 1; n <= 4; n++) begin
      checks++;
      if (rf_read(AW'(n)) !== DW'(n)) begin
        errors++; $display("FAIL contested_rf r%0d: got %h required %0h", n, rf_read(AW'(n)), n);
      end
    end
  endtask

  task automatic test_same_addr_and_r0();
    step(1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 32'h0);
    step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    checks++;
    if ({o_ar, o_br} !== 2'b01 || o_wreg !== 5'd7 || o_wdata !== 32'h2) begin
      errors++; $display("FAIL same_addr_first: got %b%b %0d/%h required 01 7/2", o_ar, o_br, o_wreg, o_wdata);
    end
    step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0);
    checks++;
    if ({o_ar, o_br} !== 2'b10 || o_wdata !== 32'h1) begin
      errors++; $display("FAIL same_addr_second: got %b%b data %h required 10 1", o_ar, o_br, o_wdata);
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (rf_read(5'd7) !== 32'h1) begin
      errors++; $display("FAIL same_addr_rf: got %h required 1", rf_read(5'd7));
    end
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    checks++;
    if (o_ar !== 1'b1) begin
      errors++; $display("FAIL r0_accept: got %b required 1", o_ar);
    end
    checks++;
    if (o_rw !== 1'b0 || o_wreg !== 5'd0 || o_wdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL r0_suppress: got %b/%0d/%h required 0/0/ffffffff", o_rw, o_wreg, o_wdata);
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (rf_read(5'd6) !== 32'h6) begin
      errors++; $display("FAIL r6_rf: got %h required 6", rf_read(5'd6));
    end
  endtask

  task automatic test_reset_mid_sweep();
    test_reset(2);
    test_init_sweep(9, 1'b1);
    Reset = 1'b1;
    bus.A_Valid = 1'b1; bus.B_Valid = 1'b1;
    @(negedge Clk);
    checks++;
    if ({bus.A_Ready, bus.B_Ready} !== 2'b00) begin
      errors++; $display("FAIL midreset_ready: got %b%b required 00", bus.A_Ready, bus.B_Ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.InitDone !== 1'b0 || bus.WriteRegister !== 5'd0) begin
      errors++; $display("FAIL midreset_out: got rw=%b done=%b reg=%0d required 0/0/0", bus.RegWrite, bus.InitDone, bus.WriteRegister);
    end
    Reset = 1'b0;
    m_arb = 1'b0; m_ptr_b = 1'b0;
    test_init_sweep(NR - 1, 1'b1);
  endtask

  task automatic test_fairness_random();
    bit            a_pend, b_pend;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    int            a_wait, b_wait;
    a_pend = 1'b0; b_pend = 1'b0; a_wait = 0; b_wait = 0;
    a_addr = 5'd0; b_addr = 5'd0; a_data = 32'h0; b_data = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; a_addr = 5'($urandom_range(0, 31)); a_data = $urandom;
      end
      if (!b_pend && $urandom_range(0, 3) != 0) begin
        b_pend = 1'b1; b_addr = 5'($urandom_range(0, 31)); b_data = $urandom;
      end
      step(a_pend, a_addr, a_data, b_pend, b_addr, b_data);
      checks++;
      if ({o_ar, o_br} !== {e_ga, e_gb}) begin
        errors++; $display("FAIL rand_ready c=%0d: got %b%b required %b%b", c, o_ar, o_br, e_ga, e_gb);
      end
      checks++;
      if (o_rw !== m_rw || o_wreg !== m_wreg || o_wdata !== m_wdata) begin
        errors++; $display("FAIL rand_write c=%0d: got %b/%0d/%h required %b/%0d/%h", c, o_rw, o_wreg, o_wdata, m_rw, m_wreg, m_wdata);
      end
      if (a_pend && b_pend) begin
        a_wait = o_ar ? 0 : a_wait + 1;
        b_wait = o_br ? 0 : b_wait + 1;
        checks++;
        if (a_wait > 1 || b_wait > 1) begin
          errors++; $display("FAIL fairness c=%0d: got waits A=%0d B=%0d required <=1", c, a_wait, b_wait);
        end
      end
      if (o_ar) begin a_pend = 1'b0; a_wait = 0; end
      if (o_br) begin b_pend = 1'b0; b_wait = 0; end
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int r = 1; r < NR; r++) begin
      checks++;
      if (rf_read(AW'(r)) !== m_rf[r]) begin
        errors++; $display("FAIL rand_rf r%0d: got %h required %h", r, rf_read(AW'(r)), m_rf[r]);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; fill = 1'b1;
    bus.A_Valid = 1'b0; bus.A_Addr = 5'd0; bus.A_Data = 32'h0;
    bus.B_Valid = 1'b0; bus.B_Addr = 5'd0; bus.B_Data = 32'h0;
    for (int r = 0; r < NR; r++) m_rf[r] = 32'h0;
    test_reset(2);
    test_init_sweep(NR - 1, 1'b0);
    test_single_write();
    test_contested();
    test_same_addr_and_r0();
    test_reset_mid_sweep();
    test_fairness_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the single write port of the 32x32 register file (`regfile`) and shares it between two write requesters, A and B, using valid/ready handshakes with round-robin arbitration. After reset it first runs an init sweep that writes INIT_VALUE to registers 1..NUM_REGS-1, so the file has known contents. It sits between the execute/writeback stages and the `regfile` RegWrite/WriteRegister/WriteData inputs. It sustains one write per cycle.

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
ADDR_WIDTH, 5, register address width (log2 NUM_REGS).
DATA_WIDTH, 32, register data width.
INIT_VALUE, 0, value written to every register 1..NUM_REGS-1 during the init sweep.

Ports:
Clk  input  1  clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
A_Valid  input  1  requester A has a write pending.
A_Ready  output  1  arbiter accepts A this cycle (combinational).
A_Addr  input  ADDR_WIDTH  A target register.
A_Data  input  DATA_WIDTH  A write data.
B_Valid  input  1  requester B has a write pending.
B_Ready  output  1  arbiter accepts B this cycle (combinational).
B_Addr  input  ADDR_WIDTH  B target register.
B_Data  input  DATA_WIDTH  B write data.
RegWrite  output  1  to regfile write enable (registered).
WriteRegister  output  ADDR_WIDTH  to regfile write address (registered).
WriteData  output  DATA_WIDTH  to regfile write data (registered).
InitDone  output  1  high once the init sweep is complete (registered).

Behaviour:
- Reset is sampled at posedge Clk.
  - Reset values: RegWrite=0, WriteRegister=0, WriteData=0, InitDone=0.
  - Internal state: state=INIT, sweep counter cnt=1, priority pointer=A.
- A_Ready and B_Ready are 0 whenever Reset=1 or state=INIT.
- States: INIT and ARB.
- INIT state:
  - Each posedge with Reset=0 loads RegWrite=1, WriteRegister=cnt, WriteData=INIT_VALUE, then increments cnt.
  - The edge that loads cnt=NUM_REGS-1 also sets state=ARB and InitDone=1.
  - The sweep takes NUM_REGS-1 edges (31 by default) after Reset falls.
  - Register 0 is never written by the sweep.
- ARB state, arbitration (combinational each cycle):
  - Only A_Valid=1: A_Ready=1.
  - Only B_Valid=1: B_Ready=1.
  - Both valid: grant the requester named by the priority pointer.
  - Neither valid: both Ready=0.
  - At most one Ready is high in any cycle.
- Transfer occurs when Valid&&Ready at a posedge.
- Priority pointer update:
  - Toggles to the other requester after every transfer in which both were valid.
  - After an uncontested transfer, the pointer points to the requester that was not granted.
- Output update:
  - On a transfer, the next edge loads WriteRegister=granted Addr, WriteData=granted Data, and RegWrite=1 if Addr!=0, otherwise RegWrite=0.
  - A write to register 0 is accepted (Ready=1) but suppressed.
  - With no transfer, the edge loads RegWrite=0; WriteRegister and WriteData hold.
- Latency: request accepted in cycle N is presented to regfile in cycle N+1 and written into the file at the end of cycle N+1.
- Throughput: one accepted write per cycle, back-to-back, including in the cycle immediately after the last INIT write.
- Requester rule: Addr and Data must stay stable while Valid=1 and Ready=0. Valid must not drop before acceptance. The arbiter does not check this.
- Same Addr from A and B in the same cycle: no merging. Writes are serialised in grant order, so the later grant's data wins.
- Reset asserted mid-sweep or mid-traffic:
  - The next edge returns to INIT with cnt=1, InitDone=0, RegWrite=0, pointer=A.
  - An in-flight registered write is dropped; it was not yet clocked into the regfile.
  - The full sweep restarts.
- InitDone stays 1 until the next Reset.

Test Plan:
1. Hold Reset 2 cycles, release, no requests -> RegWrite=1 with WriteRegister=1,2,...,31 on 31 consecutive cycles, WriteData=0; InitDone rises with the last one; afterwards `regfile` reads of registers 0..31 all return 0.
2. After InitDone, A_Valid=1, A_Addr=5, A_Data=32'hDEADBEEF for 1 cycle -> A_Ready=1 that cycle; next cycle RegWrite=1, WriteRegister=5, WriteData=DEADBEEF; ReadData1 at register 5 = DEADBEEF afterwards.
3. A and B both valid continuously for 4 accepts (A: addrs 1,2; B: addrs 3,4; data = addr) -> grant order A,B,A,B with exactly one Ready per cycle; register n reads n.
4. Both target register 7 (A_Data=1, B_Data=2), pointer=B -> B granted first, then A; register 7 reads 1. A single write to register 0 with data FFFFFFFF -> accepted, RegWrite stays 0, register 0 reads 0.
5. Assert Reset at sweep cycle 10, release -> RegWrite=0 and InitDone=0 the cycle after Reset; sweep restarts at WriteRegister=1 and runs the full 31 cycles; Ready stays 0 throughout.
6. A_Valid=1 held with B winning 3 consecutive contested cycles is impossible -> verify A is granted within 2 cycles of any contested request, and A_Addr/A_Data are written exactly once.
